// File: rtl/apb_io_regs_pkg.sv
// Shared constants for the APB I/O register block: register byte offsets,
// control reset values and the fixed ID word.
package apb_io_regs_pkg;

    localparam int unsigned STATUS32_OFS = 32'h00;
    localparam int unsigned STATUS16_OFS = 32'h04;
    localparam int unsigned STATUS8_OFS  = 32'h08;
    localparam int unsigned CTRL32_OFS   = 32'h10;
    localparam int unsigned CTRL16_OFS   = 32'h14;
    localparam int unsigned CTRL8_OFS    = 32'h18;
    localparam int unsigned ID_OFS       = 32'h1C;

    localparam logic [31:0] CTRL32_RST = 32'h0000_0000;
    localparam logic [15:0] CTRL16_RST = 16'h1234;
    localparam logic [7:0]  CTRL8_RST  = 8'h00;

    // "Hi!" little-endian: byte0 = 'H'
    localparam logic [31:0] ID_VALUE = 32'h0021_6948;

endpackage

// File: rtl/apb_io_regs.sv
// APB slave exposing three live status inputs, three RW control registers and
// a constant ID word. clk_en doubles as PREADY, so gating the clock stalls the bus.
module apb_io_regs
    import apb_io_regs_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 4,
    parameter int APB_DATA_WIDTH = 32
) (
    input  logic                      PCLK,
    input  logic                      PRESETn,
    input  logic                      clk_en,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    input  logic                      PWRITE,
    input  logic [APB_ADDR_WIDTH+1:0] PADDR,
    input  logic [APB_DATA_WIDTH-1:0] PWDATA,
    output logic [APB_DATA_WIDTH-1:0] PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    output logic [31:0]               control32b_o,
    output logic [15:0]               control16b_o,
    output logic [7:0]                control8b_o,
    input  logic [31:0]               status32b_i,
    input  logic [15:0]               status16b_i,
    input  logic [7:0]                status8b_i
);

    localparam int AW = APB_ADDR_WIDTH;

    if (APB_DATA_WIDTH != 32) begin : g_bad_data_width
        $error("apb_io_regs: APB_DATA_WIDTH must be 32");
    end

    localparam logic [AW-1:0] IDX_STATUS32 = AW'(STATUS32_OFS >> 2);
    localparam logic [AW-1:0] IDX_STATUS16 = AW'(STATUS16_OFS >> 2);
    localparam logic [AW-1:0] IDX_STATUS8  = AW'(STATUS8_OFS >> 2);
    localparam logic [AW-1:0] IDX_CTRL32   = AW'(CTRL32_OFS >> 2);
    localparam logic [AW-1:0] IDX_CTRL16   = AW'(CTRL16_OFS >> 2);
    localparam logic [AW-1:0] IDX_CTRL8    = AW'(CTRL8_OFS >> 2);
    localparam logic [AW-1:0] IDX_ID       = AW'(ID_OFS >> 2);

    logic [AW-1:0] widx;
    logic [31:0]   rd_mux;
    logic          mapped;
    logic          is_rw;
    logic          access;
    logic          wr_en;

    logic [31:0] ctrl32_q, ctrl32_d;
    logic [15:0] ctrl16_q, ctrl16_d;
    logic [7:0]  ctrl8_q,  ctrl8_d;

    assign widx   = PADDR[AW+1:2];
    assign PREADY = clk_en;
    assign access = PSEL & PENABLE & PREADY;
    assign wr_en  = access & PWRITE;

    always_comb begin
        rd_mux = '0;
        mapped = 1'b1;
        is_rw  = 1'b0;
        case (widx)
            IDX_STATUS32: rd_mux = status32b_i;
            IDX_STATUS16: rd_mux = {16'h0, status16b_i};
            IDX_STATUS8:  rd_mux = {24'h0, status8b_i};
            IDX_CTRL32: begin
                rd_mux = ctrl32_q;
                is_rw  = 1'b1;
            end
            IDX_CTRL16: begin
                rd_mux = {16'h0, ctrl16_q};
                is_rw  = 1'b1;
            end
            IDX_CTRL8: begin
                rd_mux = {24'h0, ctrl8_q};
                is_rw  = 1'b1;
            end
            IDX_ID:       rd_mux = ID_VALUE;
            default:      mapped = 1'b0;
        endcase
    end

    // Outputs are forced quiet while reset is held, even with PSEL high.
    assign PRDATA  = (PRESETn && PSEL && !PWRITE) ? rd_mux : '0;
    assign PSLVERR = PRESETn & access & (~mapped | (PWRITE & ~is_rw));

    always_comb begin
        ctrl32_d = ctrl32_q;
        ctrl16_d = ctrl16_q;
        ctrl8_d  = ctrl8_q;
        if (wr_en) begin
            if (widx == IDX_CTRL32) ctrl32_d = PWDATA[31:0];
            if (widx == IDX_CTRL16) ctrl16_d = PWDATA[15:0];
            if (widx == IDX_CTRL8)  ctrl8_d  = PWDATA[7:0];
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            ctrl32_q <= CTRL32_RST;
            ctrl16_q <= CTRL16_RST;
            ctrl8_q  <= CTRL8_RST;
        end else begin
            ctrl32_q <= ctrl32_d;
            ctrl16_q <= ctrl16_d;
            ctrl8_q  <= ctrl8_d;
        end
    end

    assign control32b_o = ctrl32_q;
    assign control16b_o = ctrl16_q;
    assign control8b_o  = ctrl8_q;

endmodule

// File: tb/tb_apb_io_regs.sv
// Self-checking bench for apb_io_regs: directed register-map checks followed by
// randomized APB traffic compared against a register-map reference model.
module tb_apb_io_regs;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        clk_en;
    logic        PSEL, PENABLE, PWRITE;
    logic [5:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR;
    logic [31:0] control32b_o;
    logic [15:0] control16b_o;
    logic [7:0]  control8b_o;
    logic [31:0] status32b_i;
    logic [15:0] status16b_i;
    logic [7:0]  status8b_i;

    apb_io_regs dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .clk_en(clk_en),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR),
        .control32b_o(control32b_o), .control16b_o(control16b_o), .control8b_o(control8b_o),
        .status32b_i(status32b_i), .status16b_i(status16b_i), .status8b_i(status8b_i)
    );

    always #5 PCLK = ~PCLK;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state: control register contents.
    logic [31:0] m_c32;
    logic [15:0] m_c16;
    logic [7:0]  m_c8;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, act, exp);
        end
    endtask

    task automatic m_reset();
        m_c32 = 32'h0;
        m_c16 = 16'h1234;
        m_c8  = 8'h00;
    endtask

    // Register map as seen from the bus.
    task automatic ref_rd(input logic [5:0] a, output logic [31:0] d,
                          output logic mapped, output logic rw);
        d = 32'h0; mapped = 1'b1; rw = 1'b0;
        case (a[5:2])
            4'd0: d = status32b_i;
            4'd1: d = {16'h0, status16b_i};
            4'd2: d = {24'h0, status8b_i};
            4'd4: begin d = m_c32;           rw = 1'b1; end
            4'd5: begin d = {16'h0, m_c16};  rw = 1'b1; end
            4'd6: begin d = {24'h0, m_c8};   rw = 1'b1; end
            4'd7: d = 32'h0021_6948;
            default: mapped = 1'b0;
        endcase
    endtask

    task automatic chk_ctrl(input string tag);
        chk({tag, "_c32"}, control32b_o, m_c32);
        chk({tag, "_c16"}, {16'h0, control16b_o}, {16'h0, m_c16});
        chk({tag, "_c8"},  {24'h0, control8b_o},  {24'h0, m_c8});
    endtask

    // One APB transfer with `waits` access-phase cycles held off by clk_en=0.
    task automatic apb(input logic wr, input logic [5:0] addr, input logic [31:0] wdata,
                       input int waits, output logic [31:0] rd, output logic err);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata; clk_en = 1'b1;
        #1 chk("setup_slverr", {31'h0, PSLVERR}, 32'h0);
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        clk_en  = (waits == 0);
        for (int i = 0; i < waits; i++) begin
            #1;
            chk("wait_pready", {31'h0, PREADY}, 32'h0);
            chk("wait_slverr", {31'h0, PSLVERR}, 32'h0);
            chk_ctrl("wait");
            @(posedge PCLK); #1;
            if (i == waits - 1) clk_en = 1'b1;
        end
        #1;
        chk("acc_pready", {31'h0, PREADY}, 32'h1);
        rd  = PRDATA;
        err = PSLVERR;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic xfer(input logic wr, input logic [5:0] addr, input logic [31:0] wdata,
                        input int waits);
        logic [31:0] exp_d, rd;
        logic        mapped, rw, err;
        ref_rd(addr, exp_d, mapped, rw);
        apb(wr, addr, wdata, waits, rd, err);
        chk(wr ? "wr_prdata" : "rd_prdata", rd, wr ? 32'h0 : exp_d);
        chk(wr ? "wr_slverr" : "rd_slverr", {31'h0, err},
            {31'h0, !mapped || (wr && !rw)});
        if (wr && rw) begin
            case (addr[5:2])
                4'd4: m_c32 = wdata;
                4'd5: m_c16 = wdata[15:0];
                4'd6: m_c8  = wdata[7:0];
                default: ;
            endcase
        end
        #1 chk_ctrl(wr ? "post_wr" : "post_rd");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        PRESETn = 1'b0; clk_en = 1'b1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
        status32b_i = 32'h9c4e9a31; status16b_i = 16'h7832; status8b_i = 8'h2a;
        m_reset();

        // Reset state, including PREADY tracking clk_en while reset is held.
        #12;
        chk_ctrl("rst");
        chk("rst_prdata", PRDATA, 32'h0);
        chk("rst_slverr", {31'h0, PSLVERR}, 32'h0);
        chk("rst_pready1", {31'h0, PREADY}, 32'h1);
        clk_en = 1'b0; #1;
        chk("rst_pready0", {31'h0, PREADY}, 32'h0);
        clk_en = 1'b1;
        @(posedge PCLK); #2 PRESETn = 1'b1;

        xfer(1'b0, 6'h00, 32'h0, 0);
        xfer(1'b0, 6'h04, 32'h0, 0);
        xfer(1'b0, 6'h08, 32'h0, 0);
        xfer(1'b0, 6'h14, 32'h0, 0);

        xfer(1'b1, 6'h10, 32'h11223344, 0);
        xfer(1'b1, 6'h14, 32'h0000AABB, 0);
        xfer(1'b1, 6'h18, 32'h000000DD, 0);
        xfer(1'b0, 6'h10, 32'h0, 0);
        xfer(1'b0, 6'h14, 32'h0, 0);
        xfer(1'b0, 6'h18, 32'h0, 0);

        xfer(1'b0, 6'h1C, 32'h0, 0);
        xfer(1'b1, 6'h1C, 32'hFFFFFFFF, 0);
        xfer(1'b0, 6'h1C, 32'h0, 0);
        xfer(1'b0, 6'h20, 32'h0, 0);
        xfer(1'b1, 6'h00, 32'h12345678, 0);
        xfer(1'b0, 6'h00, 32'h0, 0);

        // Upper bits of narrow registers are dropped.
        xfer(1'b1, 6'h14, 32'hDEAD5A5A, 0);
        xfer(1'b1, 6'h18, 32'hBEEFCA77, 0);
        xfer(1'b0, 6'h14, 32'h0, 0);

        // Wait states: the write must land only once clk_en returns.
        xfer(1'b1, 6'h10, 32'hCAFEF00D, 2);
        xfer(1'b0, 6'h10, 32'h0, 1);

        // Randomized traffic with live-changing status inputs.
        for (int n = 0; n < 80; n++) begin
            status32b_i = $urandom;
            status16b_i = 16'($urandom);
            status8b_i  = 8'($urandom);
            xfer(1'($urandom_range(0, 1)),
                 6'({4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))}),
                 $urandom, int'($urandom_range(0, 2)));
        end

        // Async reset between transfers: controls drop immediately, no edge needed.
        xfer(1'b1, 6'h10, 32'h55AA55AA, 0);
        xfer(1'b1, 6'h14, 32'h00004321, 0);
        xfer(1'b1, 6'h18, 32'h000000EE, 0);
        @(posedge PCLK); #3 PRESETn = 1'b0;
        m_reset();
        #1 chk_ctrl("async_rst");
        @(posedge PCLK); #2 PRESETn = 1'b1;

        // Reset during the access phase of a write discards that write.
        xfer(1'b1, 6'h10, 32'h0F0F0F0F, 0);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PWRITE = 1'b1; PADDR = 6'h10; PWDATA = 32'hA5A5A5A5; PENABLE = 1'b0;
        @(posedge PCLK); #1 PENABLE = 1'b1;
        #2 PRESETn = 1'b0;
        m_reset();
        #1;
        chk_ctrl("midxfer_rst");
        chk("midxfer_slverr", {31'h0, PSLVERR}, 32'h0);
        @(posedge PCLK); #1;
        chk_ctrl("midxfer_after_edge");
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        #2 PRESETn = 1'b1;
        xfer(1'b0, 6'h10, 32'h0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_io_regs.md
Name: apb_io_regs

Overview:
- APB slave register block, 32-bit data.
- Exposes three read-only status inputs (32/16/8-bit), three read/write control output registers (32/16/8-bit) and a constant ID word.
- Sits between a system APB interconnect and local I/O logic.
- Includes a clock-enable input for clock gating of register updates.

Parameters:
- APB_ADDR_WIDTH, 4, number of word-index bits; PADDR is APB_ADDR_WIDTH+2 bits wide, giving 16 word slots at byte addresses 0x00–0x3C.
- APB_DATA_WIDTH, 32, data bus width; only 32 is supported, and elaboration errors on any other value.

Ports:
- PCLK  in  1  APB clock, the single clock.
- PRESETn  in  1  asynchronous active-low reset.
- clk_en  in  1  clock enable; 0 freezes all register updates.
- PSEL  in  1  slave select.
- PENABLE  in  1  access phase.
- PWRITE  in  1  1=write, 0=read.
- PADDR  in  APB_ADDR_WIDTH+2  byte address; bits [1:0] ignored.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data.
- PREADY  out  1  transfer ready.
- PSLVERR  out  1  transfer error.
- control32b_o  out  32  control register 32-bit.
- control16b_o  out  16  control register 16-bit.
- control8b_o  out  8  control register 8-bit.
- status32b_i  in  32  status input.
- status16b_i  in  16  status input.
- status8b_i  in  8  status input.

Behaviour:
- Clock and reset: one clock, PCLK; reset PRESETn is asynchronous, active-low.
- Register map (word index = PADDR[APB_ADDR_WIDTH+1:2]):
  - 0x00 STATUS32, RO, reads status32b_i.
  - 0x04 STATUS16, RO, reads {16'h0, status16b_i}.
  - 0x08 STATUS8, RO, reads {24'h0, status8b_i}.
  - 0x10 CTRL32, RW, reset 0x00000000.
  - 0x14 CTRL16, RW, reset 0x1234; write takes PWDATA[15:0]; read {16'h0, value}.
  - 0x18 CTRL8, RW, reset 0x00; write takes PWDATA[7:0]; read {24'h0, value}.
  - 0x1C ID, RO, constant 0x00216948 ("Hi!" little-endian, byte0=0x48).
  - All other offsets are unmapped.
- Reset (PRESETn=0, async): controls go to their reset values immediately. PRDATA=0, PSLVERR=0. PREADY follows clk_en.
- PREADY = clk_en (combinational). clk_en=0 inserts wait states; the transfer completes on the first access-phase cycle with clk_en=1.
- Write commit: on the PCLK rising edge where PSEL & PENABLE & PWRITE & PREADY are all 1, to a RW offset. The output is visible the cycle after. This gives zero wait states with clk_en=1; a full transfer is 2 cycles (setup + access).
- Read: PRDATA is combinational from PADDR while PSEL & ~PWRITE; otherwise PRDATA=0. Status inputs are sampled live; they need no internal synchronisation.
- PSLVERR (combinational) is asserted only in the access phase with PREADY=1 when:
  - the address is unmapped (read returns 0, write ignored), or
  - the access is a write to an RO offset (write ignored).
- Setup phase (PENABLE=0) never modifies state.
- Control registers hold their value while clk_en=0 or while there is no valid write.
- PSEL deasserted: PRDATA=0, PSLVERR=0, no state change.
- Reset asserted mid-transfer: registers reset at once, and the in-flight write is discarded.
- Upper PWDATA bits for 16/8-bit registers are ignored.

Decomposition:
- Shared package apb_io_regs_pkg holds:
  - address offsets (STATUS32_OFS … ID_OFS);
  - reset constants: CTRL16_RST=16'h1234, CTRL32_RST=0, CTRL8_RST=0;
  - ID_VALUE=32'h00216948.
- No sub-module; the block is a single flat module containing address decode, write-enable logic, register flops and the read mux.

Test Plan:
- After reset, status32b_i=0x9c4e9a31, status16b_i=0x7832, status8b_i=0x2a. Read 0x00/0x04/0x08/0x14 -> 0x9c4e9a31 / 0x00007832 / 0x0000002a / 0x00001234, each with PSLVERR=0.
- Write 0x10=0x11223344, 0x14=0x0000AABB, 0x18=0x000000DD. Read back -> 0x11223344 / 0x0000AABB / 0x000000DD; control outputs match.
- Read 0x1C -> 0x00216948. Write 0x1C=0xFFFFFFFF -> PSLVERR=1, and a subsequent read is still 0x00216948.
- Read 0x20 -> PRDATA=0, PSLVERR=1. Write 0x00=0x12345678 -> PSLVERR=1, and STATUS32 still reflects the input.
- Hold clk_en=0 during the access phase of a write 0x10=0xCAFEF00D -> PREADY=0 and CTRL32 unchanged. Raise clk_en -> PREADY=1, and CTRL32=0xCAFEF00D next cycle.
- Assert PRESETn=0 asynchronously after writes -> control outputs immediately return to 0x0 / 0x1234 / 0x00.
